// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: controller state
// encoding and the iteration-counter width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must hold WIDTH+1 (the iteration count) without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// N-bit adder/subtractor: y = sub ? a - b : a + b, with the subtraction
// done as a + ~b + 1 so a single carry chain serves both operations.
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  logic [N-1:0] w_b;

  assign w_b = b ^ {N{sub}};
  assign y   = a + w_b + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with run-time signed/unsigned mode.
// One add/subtract and one arithmetic right shift of {A,Q,q_1} per cycle.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start moves
// the block into RUN (busy=1) for WIDTH+1 cycles, after which done pulses
// for exactly one cycle and product becomes valid. product then stays
// stable until the next operation completes; start in RUN is ignored.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  // One extra bit keeps unsigned operands positive and keeps the extended
  // multiplicand away from the most-negative value, so A never overflows.
  localparam int E = WIDTH + 1;

  state_e             r_state;
  state_e             w_next;
  logic [E-1:0]       r_a;
  logic [E-1:0]       r_q;
  logic [E-1:0]       r_m;
  logic               r_q1;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic               w_sub;
  logic [E-1:0]       w_sum;
  logic [E-1:0]       w_a_op;
  logic [E-1:0]       w_a_sh;
  logic [E-1:0]       w_q_sh;

  function automatic logic [E-1:0] ext(input logic sgn, input logic [WIDTH-1:0] x);
    return sgn ? {x[WIDTH-1], x} : {1'b0, x};
  endfunction

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));

  // Booth recoding of {Q[0], q_1}: 10 subtracts M, 01 adds M, else keep A.
  assign w_sub  = r_q[0] & ~r_q1;
  assign w_a_op = (r_q[0] ^ r_q1) ? w_sum : r_a;
  assign w_a_sh = {w_a_op[E-1], w_a_op[E-1:1]};
  assign w_q_sh = {w_a_op[0], r_q[E-1:1]};

  booth_addsub #(.N(E)) u_addsub (
    .a   (r_a),
    .b   (r_m),
    .sub (w_sub),
    .y   (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = w_accept ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
    dbg_state = r_state;
    product   = r_product;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_q   <= ext(is_signed, multiplier);
      r_m   <= ext(is_signed, multiplicand);
      r_q1  <= 1'b0;
      r_cnt <= CNT_W'(E);
    end else if (r_state == RUN) begin
      r_a   <= w_a_sh;
      r_q   <= w_q_sh;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        // Low 2*WIDTH bits of the final {A,Q}.
        r_product <= {w_a_sh[WIDTH-2:0], w_q_sh};
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq (WIDTH=8): table of hand-computed
// products plus sequences for ignored start, back-to-back and reset abort.
module tb_booth_mult_seq;

  localparam int W = 8;

  typedef struct {
    logic         sgn;
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [2*W-1:0] exp;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: product of the extended operands, reduced mod 2^(2W).
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] m,
                                            input logic [W-1:0] q);
    logic [2*W-1:0] em;
    logic [2*W-1:0] eq;
    em = sgn ? {{W{m[W-1]}}, m} : {{W{1'b0}}, m};
    eq = sgn ? {{W{q[W-1]}}, q} : {{W{1'b0}}, q};
    return em * eq;
  endfunction

  // Bounded wait for done; lat = posedges elapsed since the call.
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // driver: one complete operation with full handshake checks
  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [2*W-1:0] exp);
    int lat;
    logic [2*W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    is_signed    = sgn;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(name, lat);
    e = exp_q.pop_front();
    check({name, "_latency"}, 64'(lat), 64'(W + 1));
    check({name, "_product"}, 64'(product), 64'(e));
    check({name, "_busy_in_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_held"}, 64'(product), 64'(e));
  endtask

  vec_t tbl[15];

  initial begin
    int lat;
    int pulses;
    int first_e;
    logic [2*W-1:0] first_p;
    logic rs;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    n_vec = 0;
    n_err = 0;
    tbl[0]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    tbl[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[4]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    tbl[5]  = '{1'b1, 8'h00, 8'hFF, 16'h0000};
    tbl[6]  = '{1'b0, 8'h07, 8'h06, 16'h002A};
    tbl[7]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    tbl[8]  = '{1'b0, 8'h80, 8'h02, 16'h0100};
    tbl[9]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    tbl[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    tbl[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    tbl[12] = '{1'b0, 8'hC8, 8'h64, 16'h4E20};
    tbl[13] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};
    tbl[14] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};

    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].m, tbl[i].q, tbl[i].exp);
    end

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    is_signed = 1'b0; multiplicand = 8'd7; multiplier = 8'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    multiplicand = 8'd2; multiplier = 8'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0; first_e = 0; first_p = '0;
    for (int e = 5; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_e = e;
          first_p = product;
        end
      end
    end
    check("ignore_pulses", 64'(pulses), 64'd1);
    check("ignore_latency", 64'(first_e), 64'(W + 1));
    check("ignore_product", 64'(first_p), 64'h002A);

    // back-to-back: start held into the DONE cycle
    @(negedge clk);
    is_signed = 1'b0; multiplicand = 8'd3; multiplier = 8'd4; start = 1'b1;
    @(posedge clk);
    #1;
    multiplicand = 8'd10; multiplier = 8'd10;
    wait_done("b2b_first", lat);
    check("b2b_first_latency", 64'(lat), 64'(W + 1));
    check("b2b_first_product", 64'(product), 64'h000C);
    wait_done("b2b_second", lat);
    start = 1'b0;
    check("b2b_second_latency", 64'(lat), 64'(W + 2));
    check("b2b_second_product", 64'(product), 64'h0064);
    repeat (2) @(posedge clk);

    // reset abort mid-RUN
    @(negedge clk);
    is_signed = 1'b0; multiplicand = 8'd7; multiplier = 8'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 1'b0, 8'd2, 8'd3, 16'h0006);

    // random operands against the reference model
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      rm = W'($urandom_range(0, 255));
      rq = W'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", i), rs, rm, rq, model(rs, rm, rq));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
